dest_tag_pipe: RTL
==================

# dest_tag_pipe

Producer side of the forwarding/hazard interface. Tracks the destination-register tag of every instruction from decode through the A (execute), M (memory) and W (writeback) stages. Generates the `dreg_*`, `*nop` and `EX_LW` signals that the forwarding unit consumes. Also keeps a per-register pending-write scoreboard (busy vector) that decode and debug logic read.

## Interface
Parameters
- `NREG`, 64: architectural register count; tag width is 6 bits, fixed.
- `CNTW`, 2: width of each per-register pending counter; must hold the value 3 (A+M+W).

Ports
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  decode holds a real instruction this cycle.
- `id_wr`  in  1  the decode instruction writes a register.
- `id_dreg`  in  6  destination register number in decode (the `setBusy` value).
- `id_is_lw`  in  1  the decode instruction is a load.
- `stall`  in  1  load-use stall from the forwarding unit; decode is held and a bubble enters A.
- `flush`  in  1  branch redirect; the decode instruction and the A-stage entry are squashed.
- `dreg_A`, `dreg_M`, `dreg_W`  out  6 each  destination tag held in each stage.
- `anop`, `mnop`, `wnop`  out  1 each  1 = the stage holds a bubble or a non-writing instruction.
- `EX_LW`  out  1  the A stage holds a valid load that writes a nonzero register.
- `rf_we`  out  1  equal to `!wnop`; register-file write enable for `dreg_W`.
- `busy`  out  NREG  `busy[r]` = 1 when register r has at least one in-flight writer in A/M/W.

## Operation
- Each stage register holds `{valid, dreg, is_lw}`. The output `xnop` is `!valid`.
- Issue condition: `id_valid && id_wr && id_dreg != 0 && !stall && !flush`.
  - When the issue condition is true, A loads `{1, id_dreg, id_is_lw}`.
  - Otherwise A loads `{0, 0, 0}`.
  - A writer to r0 is always treated as a nop.
- M loads A and W loads M every cycle. A stall does not freeze A, M or W; it only inserts a bubble into A.
- `flush` overrides `stall`:
  - A loads a bubble.
  - The entry currently in A is discarded; it is not passed to M.
  - M still loads a bubble that cycle.
- Pending counters `cnt[r]` (r = 1..63; `cnt[0]` is tied to 0). Per cycle, the net change is the sum of:
  - +1 on `id_dreg` if the issue condition is true;
  - −1 on `dreg_W` if `!wnop` (the entry retires);
  - −1 on `dreg_A` if `flush && !anop` (the entry is squashed).
- All three events may hit the same register in one cycle; the net result (−2..+1) is applied in a single update.
- The counter never underflows or overflows in legal use. If a decrement would take a counter below 0, it saturates at 0.
- `busy[r] = (cnt[r] != 0)`. `busy[0]` is always 0.
- `EX_LW = !anop && a_is_lw`.

## Timing
- Reset (synchronous): all stages are bubbles and all counters are 0. Outputs during reset and in the first cycle after it:
  - `dreg_A/M/W` = 0;
  - `anop/mnop/wnop` = 1;
  - `EX_LW` = 0, `rf_we` = 0, `busy` = 0.
- Reset asserted mid-operation discards all in-flight entries. No retire decrements are applied in that cycle.
- An instruction issued in cycle n appears in:
  - A during n+1 (`EX_LW` also valid in n+1 for a load);
  - M during n+2;
  - W during n+3, with `rf_we` = 1.
- Busy lifetime for that instruction:
  - `busy` rises in n+1 (registered).
  - It falls in n+4, provided no other writer to the same register is pending.
- Stall in cycle n: A holds a bubble in n+1, M and W advance normally, and no counter increments.
- Flush in cycle n:
  - The A entry from cycle n is gone in n+1 and its counter is decremented.
  - M in n+1 is a bubble.
- Back-to-back writers to the same register raise the count to 2 or 3. `busy` stays high until the last writer retires.

## Test plan
- Reset, then issue `id_dreg`=5 (`id_wr`=1) in cycle 1 → `dreg_A`=5 / `anop`=0 in cycle 2, `dreg_M`=5 in cycle 3, `dreg_W`=5 / `rf_we`=1 in cycle 4, `busy[5]` high in cycles 2–4 and low in cycle 5.
- Load to r7 followed by a stall pulse → `EX_LW`=1 for one cycle; the next cycle has `anop`=1 and `EX_LW`=0; `cnt[7]` stays 1 while the load advances.
- Writes to r3 in three consecutive cycles → `cnt[3]` reaches 3; `busy[3]` stays high until 3 cycles after the last issue.
- Flush while A holds r9, with M holding r9 and decode issuing r9 → `cnt[9]` goes 2→1 (only M's entry remains); A and M are bubbles next cycle.
- `id_dreg`=0 with `id_wr`=1 → `anop` stays 1 and `busy` stays 0. Same-cycle W retire of r4 plus issue of r4 → `cnt[4]` unchanged.
- Reset asserted with all three stages full → the next cycle shows all nops, `busy` = 0 and `rf_we` = 0.

Source files
------------

// File: rtl/dest_tag_pipe_if.sv
// Bundle between decode/forwarding logic and the destination-tag pipeline.
// The master drives decode-side requests; the slave produces the stage tags and the busy vector.
interface dest_tag_pipe_if #(
  parameter int unsigned NREG = 64
);
  logic            id_valid;
  logic            id_wr;
  logic [5:0]      id_dreg;
  logic            id_is_lw;
  logic            stall;
  logic            flush;
  logic [5:0]      dreg_A;
  logic [5:0]      dreg_M;
  logic [5:0]      dreg_W;
  logic            anop;
  logic            mnop;
  logic            wnop;
  logic            EX_LW;
  logic            rf_we;
  logic [NREG-1:0] busy;

  modport master (
    output id_valid, id_wr, id_dreg, id_is_lw, stall, flush,
    input  dreg_A, dreg_M, dreg_W, anop, mnop, wnop, EX_LW, rf_we, busy
  );

  modport slave (
    input  id_valid, id_wr, id_dreg, id_is_lw, stall, flush,
    output dreg_A, dreg_M, dreg_W, anop, mnop, wnop, EX_LW, rf_we, busy
  );
endinterface

// File: rtl/dest_tag_pipe.sv
// Destination-tag pipeline for A/M/W plus a per-register pending-write scoreboard.
// Feeds the forwarding unit (dreg_*, *nop, EX_LW) and decode/debug (busy).
module dest_tag_pipe #(
  parameter int unsigned NREG = 64,
  parameter int unsigned CNTW = 2
) (
  input logic             clk,
  input logic             reset,
  dest_tag_pipe_if.slave  bus
);
  localparam int CntMax = (1 << CNTW) - 1;

  logic            r_a_valid, r_m_valid, r_w_valid;
  logic [5:0]      r_a_dreg, r_m_dreg, r_w_dreg;
  logic            r_a_lw, r_m_lw, r_w_lw;
  logic [CNTW-1:0] r_cnt [NREG];

  logic            w_issue;
  logic [CNTW-1:0] w_cnt_d [NREG];

  assign w_issue = bus.id_valid && bus.id_wr && (bus.id_dreg != 6'd0) && !bus.stall && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_valid <= 1'b0;
      r_a_dreg  <= 6'd0;
      r_a_lw    <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_dreg  <= 6'd0;
      r_m_lw    <= 1'b0;
      r_w_valid <= 1'b0;
      r_w_dreg  <= 6'd0;
      r_w_lw    <= 1'b0;
    end else begin
      r_a_valid <= w_issue;
      r_a_dreg  <= w_issue ? bus.id_dreg : 6'd0;
      r_a_lw    <= w_issue && bus.id_is_lw;
      // A flushed entry dies in A; M receives a bubble instead.
      r_m_valid <= bus.flush ? 1'b0 : r_a_valid;
      r_m_dreg  <= bus.flush ? 6'd0 : r_a_dreg;
      r_m_lw    <= bus.flush ? 1'b0 : r_a_lw;
      r_w_valid <= r_m_valid;
      r_w_dreg  <= r_m_dreg;
      r_w_lw    <= r_m_lw;
    end
  end

  always_comb begin
    for (int r = 0; r < int'(NREG); r++) begin
      w_cnt_d[r] = '0;
    end
    for (int r = 1; r < int'(NREG); r++) begin
      int v;
      v = int'(r_cnt[r]);
      if (w_issue && bus.id_dreg == 6'(r)) v = v + 1;
      if (r_w_valid && r_w_dreg == 6'(r)) v = v - 1;
      if (bus.flush && r_a_valid && r_a_dreg == 6'(r)) v = v - 1;
      // Clamp so an illegal sequence cannot wrap the counter.
      if (v < 0) v = 0;
      if (v > CntMax) v = CntMax;
      w_cnt_d[r] = CNTW'(v);
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < int'(NREG); r++) begin
      if (reset) begin
        r_cnt[r] <= '0;
      end else begin
        r_cnt[r] <= w_cnt_d[r];
      end
    end
  end

  always_comb begin
    bus.busy = '0;
    for (int r = 1; r < int'(NREG); r++) begin
      bus.busy[r] = (r_cnt[r] != '0);
    end
  end

  assign bus.dreg_A = r_a_dreg;
  assign bus.dreg_M = r_m_dreg;
  assign bus.dreg_W = r_w_dreg;
  assign bus.anop   = !r_a_valid;
  assign bus.mnop   = !r_m_valid;
  assign bus.wnop   = !r_w_valid;
  assign bus.EX_LW  = r_a_valid && r_a_lw;
  assign bus.rf_we  = r_w_valid;

  logic w_unused;
  assign w_unused = r_w_lw;
endmodule
